// File: rtl/robs_div.sv
// Signed 2N/N restoring divider: N+2 edges per result, 1 edge for div-by-zero or early overflow.
// No backpressure: start is taken only in IDLE/DONE and ignored while busy; results hold in DONE.
module robs_div #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           done,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N:0] QMAX_POS = (N+1)'((2 ** (N - 1)) - 1);
    localparam logic [N:0] QMAX_NEG = (N+1)'(2 ** (N - 1));

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [N-1:0]  dsr_q, dsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rmd_q, rmd_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;

    // One extra bit so that the most negative dividend/divisor negate without loss.
    logic [2*N:0] dvd_ext, dvd_abs;
    logic [N:0]   dsr_ext, dsr_abs;
    logic [N:0]   trial, diff;
    logic         ge;
    logic         accept;

    assign dvd_ext = {dividend[2*N-1], dividend};
    assign dvd_abs = dividend[2*N-1] ? -dvd_ext : dvd_ext;
    assign dsr_ext = {divisor[N-1], divisor};
    assign dsr_abs = divisor[N-1] ? -dsr_ext : dsr_ext;

    assign trial  = {rem_q, lo_q[N-1]};
    assign diff   = trial - {1'b0, dsr_q};
    assign ge     = (trial >= {1'b0, dsr_q});
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        done_d  = done_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    qneg_d = dividend[2*N-1] ^ divisor[N-1];
                    rneg_d = dividend[2*N-1];
                    rem_d  = dvd_abs[2*N-1:N];
                    lo_d   = dvd_abs[N-1:0];
                    dsr_d  = dsr_abs[N-1:0];
                    cnt_d  = CW'(N);
                    done_d = 1'b0;
                    dz_d   = 1'b0;
                    ov_d   = 1'b0;
                    if (divisor == '0) begin
                        quo_d   = '0;
                        rmd_d   = dividend[N-1:0];
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (dvd_abs[2*N:N] >= dsr_abs) begin
                        quo_d   = '0;
                        rmd_d   = '0;
                        ov_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                rem_d = ge ? diff[N-1:0] : trial[N-1:0];
                lo_d  = {lo_q[N-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if ({1'b0, lo_q} > (qneg_q ? QMAX_NEG : QMAX_POS)) begin
                    quo_d = '0;
                    rmd_d = '0;
                    ov_d  = 1'b1;
                end else begin
                    quo_d = qneg_q ? -lo_q : lo_q;
                    rmd_d = rneg_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            lo_q    <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;

endmodule

// File: doc/robs_div.md
ROBS_DIV -- requirements
Module: robs_div

Interface
REQ-001 N, 8, divisor/quotient/remainder width; dividend is 2N bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 dividend  input  2N  two's-complement dividend; captured on the accepting edge.
REQ-006 divisor  input  N  two's-complement divisor; captured on the accepting edge.
REQ-007 quotient  output  N  two's-complement quotient, registered.
REQ-008 remainder  output  N  two's-complement remainder, registered.
REQ-009 done  output  1  result valid, registered.
REQ-010 div_by_zero  output  1  divisor was zero, registered.
REQ-011 overflow  output  1  quotient not representable in N signed bits, registered.

Function
REQ-012 States: IDLE, ITER, FIX, DONE; one-hot or binary encoding is free.
REQ-013 Accepting edge: rising edge with state IDLE or DONE and start=1.
- Captures the operands.
- Latches the result signs: quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
- Loads |dividend|, |divisor| and the iteration counter.
- Clears done, div_by_zero and overflow.
REQ-014 Accepting edge with divisor=0 -> DONE: quotient=0, remainder=dividend[N-1:0], div_by_zero=1; done high after that edge (latency 1).
REQ-015 Accepting edge with |dividend|[2N-1:N] >= |divisor| (nonzero divisor) -> DONE: quotient=0, remainder=0, overflow=1, latency 1.
REQ-016 Otherwise the accepting edge enters ITER.
REQ-017 ITER performs one unsigned restoring step per cycle, for exactly N cycles:
- Shift the partial remainder left and bring in the next dividend bit.
- Trial-subtract |divisor|; keep the difference and shift in quotient bit 1 if it is non-negative, else restore and shift in 0.
- After the Nth step -> FIX.
REQ-018 FIX, one cycle:
- Apply the latched signs to the unsigned quotient and remainder.
- Set overflow=1, quotient=0, remainder=0 if the unsigned quotient exceeds 2^(N-1)-1 for a positive result or 2^(N-1) for a negative result.
- Then -> DONE.
REQ-019 Normal latency: done high after the (N+2)th rising edge counting the accepting edge as the first; 10 edges for N=8.
REQ-020 Division truncates toward zero; a nonzero remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-021 DONE holds quotient, remainder, done and the flags stable indefinitely while start=0.
REQ-022 start=1 in DONE is a new accepting edge; done drops on that edge.
REQ-023 start during ITER or FIX is ignored; the operation in progress is unaffected.
REQ-024 Operand input changes after the accepting edge have no effect on the result.
REQ-025 A dividend of -2^(2N-1) is handled without internal width loss: absolute values carry 2N+1 bits internally as needed.

Reset
REQ-026 reset=1 forces, asynchronously: state=IDLE, quotient=0, remainder=0, done=0, div_by_zero=0, overflow=0, counter=0.
REQ-027 reset asserted mid-ITER or mid-FIX aborts the operation; no partial result appears; done stays 0 until a later complete operation.
REQ-028 First accepting edge is the first rising edge after reset deasserts with start=1.

Verification
REQ-029 dividend=100, divisor=7, start pulse -> done after edge 10; quotient=14 (0x0E), remainder=2, flags 0.
REQ-030 Sign combinations:
- -100/7 -> quotient=0xF2, remainder=0xFE.
- 100/-7 -> quotient=0xF2, remainder=0x02.
- -100/-7 -> quotient=0x0E, remainder=0xFE.
REQ-031 Divisor=0 with dividend=0x1234 -> done after edge 1; div_by_zero=1, quotient=0, remainder=0x34.
REQ-032 Overflow paths:
- 1000/3 -> early overflow, done after edge 1.
- 1024/8 -> overflow at FIX, done after edge 10.
- -1024/8 -> quotient=0x80, remainder=0, overflow=0.
REQ-033 Reset at edge 5 of 100/7 -> all outputs 0 immediately; then 50/5 -> quotient=10, remainder=0 after 10 edges.
REQ-034 Back-to-back and busy behaviour:
- start held high from DONE -> back-to-back results each 10 edges apart.
- start pulses and operand changes during ITER leave the first result unchanged.
